bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-in/serial-out stage that feeds the single-bit `din` stream of the 1011 sequence detector (`fsm_1011`).
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `dout`, with `dout_valid` qualifying each bit.
- Back-to-back words stream with no gap bit, so overlapping patterns that span word boundaries reach the detector intact.

Parameters:
- WIDTH, 8: word width in bits; legal range is 2 or more.
- MSB_FIRST, 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- IDLE_BIT, 0: value driven on `dout` whenever `dout_valid` is 0.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserts immediately, deassertion is synchronous to clk.
- load_data  input  WIDTH  word to serialize.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit, registered; feeds detector `din`.
- dout_valid  output  1  dout carries a payload bit this cycle.
- busy  output  1  1 while a word is being emitted (state SHIFT).

Behaviour:
- Reset (reset=0): state=IDLE, shift register cleared, counter cleared, dout=IDLE_BIT, dout_valid=0, busy=0, load_ready=1. Reset takes effect mid-word with no completion; the partial word is discarded.
- A transfer occurs on a rising edge where load_valid=1 and load_ready=1.
- load_ready is combinational from state only, never from load_valid: load_ready = (state==IDLE) OR (state==SHIFT AND cnt==0).
- Counter `cnt` has width $clog2(WIDTH) and holds the number of bits remaining after the one currently on dout.
- State IDLE:
  - On a transfer: capture the word; drive dout with the first bit (bit WIDTH-1 if MSB_FIRST, else bit 0); set dout_valid=1; set cnt=WIDTH-1; go to SHIFT.
  - Otherwise hold dout=IDLE_BIT and dout_valid=0.
- State SHIFT, cnt!=0: shift the register one position toward the output end; dout takes the next bit; cnt decrements. load_valid is ignored and load_ready=0.
- State SHIFT, cnt==0 (last bit on dout):
  - With a transfer: load the new word exactly as from IDLE and stay in SHIFT. There is no idle cycle, so the stream is continuous.
  - Without a transfer: go to IDLE; dout=IDLE_BIT; dout_valid=0.
- Latency: the first bit appears on dout in the cycle after the accepting edge. A WIDTH-bit word occupies exactly WIDTH consecutive cycles of dout_valid=1.
- Throughput: one bit per clock, sustained indefinitely under continuous load_valid.
- busy equals (state==SHIFT), registered.
- load_data is sampled only on the transfer edge; later changes have no effect on the word in flight.
- Reset asserted on the same edge as a transfer: reset wins and the word is not accepted.

Decomposition:
- Shared package `serial_pkg`:
  - state enum {IDLE, SHIFT}
  - localparam for the default word width
  - IDLE_BIT default constant
- No sub-module needed. The shift register, counter and 2-state FSM form one module.
- Integration is a top-level wrapper outside this block's scope: dout goes to the detector `din`; detector reset is driven from the same reset net.

Test Plan:
1. Reset values: hold reset=0 for 2 cycles, then release -> dout=0, dout_valid=0, busy=0, load_ready=1. Assert reset mid-word -> all outputs return to reset values immediately, without waiting for the next edge.
2. Single word: WIDTH=8, MSB_FIRST=1, load 8'hB0 for one cycle.
   - dout = 1,0,1,1,0,0,0,0 on the next 8 cycles with dout_valid=1.
   - load_ready=0 for the first 7 of those cycles, 1 on the 8th.
   - Then dout_valid=0 and busy=0.
3. Back-to-back: hold load_valid=1 with 8'hB6 then 8'hDA.
   - 16 consecutive valid bits: 1,0,1,1,0,1,1,0,1,1,0,1,1,0,1,0.
   - No gap cycle between words.
   - Through the wrapper, the detector asserts y 4 times, with overlap across the word boundary.
4. LSB-first: MSB_FIRST=0, load 8'h0D -> dout = 1,0,1,1,0,0,0,0.
5. Handshake stress: hold load_valid=1 and change load_data every cycle during SHIFT.
   - Only the word present on the edge where load_ready=1 is accepted.
   - Scoreboard: emitted bits exactly match the accepted words, in order.
6. Minimum width: WIDTH=2, continuous load of 2'b10 -> dout alternates 1,0 with dout_valid held at 1 and load_ready pulsing every second cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared types and defaults for the serial feeder
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int DEF_WIDTH = 8;
  localparam logic DEF_IDLE_BIT = 1'b0;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-in/serial-out stage with gapless back-to-back word streaming
module bit_serializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT = DEF_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted;
  logic [CW-1:0] cnt, cnt_n;
  logic dout_n, dv_n, xfer, adv;
  assign load_ready = state == IDLE || cnt == '0;
  assign busy = state == SHIFT;
  always_comb begin
    xfer = load_valid && load_ready;
    adv = state == SHIFT && cnt != '0;
    shifted = MSB_FIRST ? sreg << 1 : sreg >> 1;
    state_n = IDLE;
    if (xfer || adv) state_n = SHIFT;
    sreg_n = xfer ? load_data : adv ? shifted : sreg;
    cnt_n = xfer ? CW'(WIDTH - 1) : adv ? cnt - CW'(1) : '0;
    dout_n = xfer ? (MSB_FIRST ? load_data[WIDTH-1] : load_data[0]) :
             adv  ? (MSB_FIRST ? shifted[WIDTH-1] : shifted[0]) : IDLE_BIT;
    dv_n = xfer || adv;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      sreg <= '0;
      cnt <= '0;
      dout <= IDLE_BIT;
      dout_valid <= 1'b0;
    end else begin
      state <= state_n;
      sreg <= sreg_n;
      cnt <= cnt_n;
      dout <= dout_n;
      dout_valid <= dv_n;
    end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: directed self-checking bench for bit_serializer
module tb_bit_serializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] d8 = '0, dl = '0;
  logic [1:0] d2 = '0;
  logic v8 = 1'b0, vl = 1'b0, v2 = 1'b0;
  logic r8, o8, ov8, b8, rl, ol, ovl, bl, r2, o2, ov2, b2;
  int checks = 0;
  int errors = 0;
  logic [15:0] seq;
  logic [7:0] w;
  logic [3:0] win;
  int hits;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u8 (
    .clk(clk), .reset(reset), .load_data(d8), .load_valid(v8), .load_ready(r8),
    .dout(o8), .dout_valid(ov8), .busy(b8));
  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) ul (
    .clk(clk), .reset(reset), .load_data(dl), .load_valid(vl), .load_ready(rl),
    .dout(ol), .dout_valid(ovl), .busy(bl));
  bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u2 (
    .clk(clk), .reset(reset), .load_data(d2), .load_valid(v2), .load_ready(r2),
    .dout(o2), .dout_valid(ov2), .busy(b2));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_dout"}, {7'd0, o8}, 8'd0);
    chk({tag, "_dv"}, {7'd0, ov8}, 8'd0);
    chk({tag, "_busy"}, {7'd0, b8}, 8'd0);
    chk({tag, "_ready"}, {7'd0, r8}, 8'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_idle8("rst_hold");
    reset = 1'b1;
    @(negedge clk);
    chk_idle8("rst_rel");

    d8 = 8'hB0; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    seq = {8'hB0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("single_bit%0d", i), {7'd0, o8}, {7'd0, seq[15-i]});
      chk($sformatf("single_dv%0d", i), {7'd0, ov8}, 8'd1);
      chk($sformatf("single_rdy%0d", i), {7'd0, r8}, {7'd0, i == 7});
      @(negedge clk);
    end
    chk("single_end_dv", {7'd0, ov8}, 8'd0);
    chk("single_end_busy", {7'd0, b8}, 8'd0);

    d8 = 8'hB6; v8 = 1'b1;
    @(negedge clk);
    d8 = 8'hDA;
    seq = 16'b1011011011011010;
    win = '0; hits = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b2b_bit%0d", i), {7'd0, o8}, {7'd0, seq[15-i]});
      chk($sformatf("b2b_dv%0d", i), {7'd0, ov8}, 8'd1);
      win = {win[2:0], o8};
      if (i >= 3 && win == 4'b1011) hits++;
      if (i == 8) v8 = 1'b0;
      @(negedge clk);
    end
    chk("b2b_end_dv", {7'd0, ov8}, 8'd0);
    chk("b2b_pattern_hits", 8'(hits), 8'd4);

    dl = 8'h0D; vl = 1'b1;
    @(negedge clk);
    vl = 1'b0;
    dl = 8'hFF;
    seq = {8'b10110000, 8'h00};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("lsb_bit%0d", i), {7'd0, ol}, {7'd0, seq[15-i]});
      chk($sformatf("lsb_dv%0d", i), {7'd0, ovl}, 8'd1);
      @(negedge clk);
    end
    chk("lsb_end_dv", {7'd0, ovl}, 8'd0);

    d8 = 8'(5); v8 = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 24; j++) begin
      w = 8'((j / 8) * 8 * 37 + 5);
      chk($sformatf("hs_bit%0d", j), {7'd0, o8}, {7'd0, w[7 - (j % 8)]});
      chk($sformatf("hs_dv%0d", j), {7'd0, ov8}, 8'd1);
      chk($sformatf("hs_rdy%0d", j), {7'd0, r8}, {7'd0, (j % 8) == 7});
      d8 = 8'((j + 1) * 37 + 5);
      if (j >= 16) v8 = 1'b0;
      @(negedge clk);
    end
    chk("hs_end_dv", {7'd0, ov8}, 8'd0);

    d2 = 2'b10; v2 = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("w2_bit%0d", j), {7'd0, o2}, {7'd0, (j % 2) == 0});
      chk($sformatf("w2_dv%0d", j), {7'd0, ov2}, 8'd1);
      chk($sformatf("w2_rdy%0d", j), {7'd0, r2}, {7'd0, (j % 2) == 1});
      if (j == 7) v2 = 1'b0;
      @(negedge clk);
    end
    chk("w2_end_dv", {7'd0, ov2}, 8'd0);

    d8 = 8'hFF; v8 = 1'b1;
    @(negedge clk);
    v8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_pre_dv", {7'd0, ov8}, 8'd1);
    #2 reset = 1'b0;
    #1 chk_idle8("mid_rst");
    v8 = 1'b1; d8 = 8'hA5;
    @(negedge clk);
    chk("rst_wins_busy", {7'd0, b8}, 8'd0);
    chk("rst_wins_dv", {7'd0, ov8}, 8'd0);
    v8 = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk_idle8("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
